// File: rtl/lrn_issue_ctrl_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | lrn_issue_ctrl_pkg : shared state encoding, defaults, clog2 helper  |
// | Revision 1.0                                                        |
// +-------------------------------------------------------------------+
package lrn_issue_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int unsigned NUM_PE_DEF    = 4;
   localparam int unsigned CREDITS_DEF   = 4;
   localparam int unsigned COUNT_W_DEF   = 16;
   localparam int unsigned ISSUE_GAP_DEF = NUM_PE_DEF + 1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lrn_issue_ctrl_issue_pacer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | lrn_issue_ctrl_issue_pacer : issue gap down-counter + credit count  |
// | Revision 1.0                                                        |
// +-------------------------------------------------------------------+
module lrn_issue_ctrl_issue_pacer
   import lrn_issue_ctrl_pkg::*;
#(
   parameter int unsigned CREDITS   = CREDITS_DEF,
   parameter int unsigned ISSUE_GAP = ISSUE_GAP_DEF,
   parameter int unsigned INF_W     = clog2(CREDITS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fire,
   input  logic             retire,
   output logic             can_issue,
   output logic [INF_W-1:0] inflight
);

   localparam int unsigned      GAP_W      = (clog2(ISSUE_GAP) > 0) ? clog2(ISSUE_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(ISSUE_GAP - 1);
   localparam logic [INF_W-1:0] CREDIT_MAX = INF_W'(CREDITS);

   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [INF_W-1:0] inflight_q, inflight_d;
   logic             retire_ok;

   // A retire with nothing outstanding is an upstream error; never underflow.
   assign retire_ok = retire & (inflight_q != '0);

   always_comb begin
      gap_cnt_d  = gap_cnt_q;
      inflight_d = inflight_q;
      if (fire) begin
         gap_cnt_d = GAP_LOAD;
      end else if (gap_cnt_q != '0) begin
         gap_cnt_d = gap_cnt_q - 1'b1;
      end
      case ({fire, retire_ok})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gap_cnt_q  <= '0;
         inflight_q <= '0;
      end else begin
         gap_cnt_q  <= gap_cnt_d;
         inflight_q <= inflight_d;
      end
   end

   assign can_issue = (inflight_q < CREDIT_MAX) && (gap_cnt_q == '0);
   assign inflight  = inflight_q;

endmodule
`default_nettype wire

// File: rtl/lrn_issue_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | lrn_issue_ctrl : paces vector issues into the LRN datapath          |
// | Revision 1.0                                                        |
// +-------------------------------------------------------------------+
module lrn_issue_ctrl
   import lrn_issue_ctrl_pkg::*;
#(
   parameter int unsigned NUM_PE    = NUM_PE_DEF,
   parameter int unsigned CREDITS   = CREDITS_DEF,
   parameter int unsigned COUNT_W   = COUNT_W_DEF,
   parameter int unsigned ISSUE_GAP = NUM_PE + 1,
   parameter int unsigned INF_W     = clog2(CREDITS + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COUNT_W-1:0] cfg_num_vec,
   input  logic               src_valid,
   output logic               src_ready,
   output logic               norm_enable,
   input  logic               norm_out_valid,
   output logic [INF_W-1:0]   inflight,
   output logic               busy,
   output logic               done,
   output logic               err
);

   state_e             state_q, state_d;
   logic [COUNT_W-1:0] cfg_q, cfg_d;
   logic [COUNT_W-1:0] issued_q, issued_d;
   logic [COUNT_W-1:0] retired_q, retired_d;
   logic               err_q, err_d;
   logic               can_issue;
   logic               fire;
   logic               retire_ok;

   lrn_issue_ctrl_issue_pacer #(
      .CREDITS   (CREDITS),
      .ISSUE_GAP (ISSUE_GAP),
      .INF_W     (INF_W)
   ) u_pacer (
      .clk       (clk),
      .reset     (reset),
      .fire      (fire),
      .retire    (norm_out_valid),
      .can_issue (can_issue),
      .inflight  (inflight)
   );

   // Ready is independent of src_valid so upstream may wait on it.
   assign src_ready   = (state_q == ST_RUN) && can_issue && (issued_q < cfg_q);
   assign fire        = src_valid & src_ready;
   assign norm_enable = fire;
   assign retire_ok   = norm_out_valid & (inflight != '0);

   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      issued_d  = issued_q + COUNT_W'(fire);
      retired_d = retired_q + COUNT_W'(retire_ok);
      err_d     = err_q | (norm_out_valid & (inflight == '0));
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cfg_d     = cfg_num_vec;
               issued_d  = '0;
               retired_d = '0;
               state_d   = (cfg_num_vec == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (fire && ((issued_q + COUNT_W'(1)) == cfg_q)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (retired_d == cfg_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cfg_q     <= '0;
         issued_q  <= '0;
         retired_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         issued_q  <= issued_d;
         retired_q <= retired_d;
         err_q     <= err_d;
      end
   end

   assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done = (state_q == ST_DONE);
   assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lrn_issue_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_lrn_issue_ctrl : scoreboard bench for lrn_issue_ctrl             |
// | Revision 1.0                                                        |
// +-------------------------------------------------------------------+
module tb_lrn_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] cfg_num_vec = '0;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic        norm_enable;
   logic        norm_out_valid = 1'b0;
   logic [2:0]  inflight;
   logic        busy;
   logic        done;
   logic        err;

   int          cyc = 0;
   int          n_total = 0;
   int          n_bad = 0;
   int          exp_issue[$];
   int          exp_done[$];
   bit          ret_sched[0:4095];
   int          auto_lat = 0;
   bit          mon_en = 1'b0;
   bit          err_chk_en = 1'b0;

   lrn_issue_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .cfg_num_vec    (cfg_num_vec),
      .src_valid      (src_valid),
      .src_ready      (src_ready),
      .norm_enable    (norm_enable),
      .norm_out_valid (norm_out_valid),
      .inflight       (inflight),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total = n_total + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Window index = cyc: inputs set at negedge are consumed by posedge number cyc.
   initial begin
      forever begin
         @(negedge clk);
         norm_out_valid = (cyc < 4096) ? ret_sched[cyc] : 1'b0;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (mon_en) begin
            chk("fire", {31'd0, norm_enable}, {31'd0, src_valid & src_ready});
            chk("busy_done", {31'd0, busy & done}, 32'd0);
            if (norm_enable) begin
               if (exp_issue.size() == 0) chk("issue_unexp", 32'd1, 32'd0);
               else chk("issue_cyc", cyc, exp_issue.pop_front());
               if (auto_lat > 0 && cyc + auto_lat < 4096) ret_sched[cyc + auto_lat] = 1'b1;
            end
            if (done) begin
               if (exp_done.size() == 0) chk("done_unexp", 32'd1, 32'd0);
               else chk("done_cyc", cyc, exp_done.pop_front());
            end
            if (err_chk_en) chk("err_sticky", {31'd0, err}, 32'd1);
         end
      end
   end

   task automatic start_pass(input int cfg, input int n_issue, output int s);
      @(negedge clk);
      start = 1'b1;
      cfg_num_vec = cfg[15:0];
      s = cyc;
      for (int k = 0; k < n_issue; k++) exp_issue.push_back(s + 1 + 5 * k);
      @(negedge clk);
      start = 1'b0;
      cfg_num_vec = 16'hBEEF;
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (exp_done.size() == 0) break;
      end
      chk("done_left", exp_done.size(), 32'd0);
      chk("issue_left", exp_issue.size(), 32'd0);
      exp_done.delete();
      exp_issue.delete();
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ready"}, {31'd0, src_ready}, 32'd0);
      chk({tag, "_en"}, {31'd0, norm_enable}, 32'd0);
      chk({tag, "_infl"}, {29'd0, inflight}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
   endtask

   initial begin
      int s;
      int t0;
      int r;
      src_valid = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #4;
      chk_idle_outputs("rst");
      mon_en = 1'b1;

      // cfg=3, retire 8 cycles after each issue
      auto_lat = 8;
      start_pass(3, 3, s);
      t0 = s + 1;
      exp_done.push_back(t0 + 19);
      repeat (12) @(negedge clk);
      #4;
      chk("drain_busy", {31'd0, busy}, 32'd1);
      chk("drain_ready", {31'd0, src_ready}, 32'd0);
      wait_done(100);

      // cfg=6, credits exhausted until the first retire
      auto_lat = 0;
      start_pass(6, 4, s);
      t0 = s + 1;
      r = t0 + 20;
      ret_sched[r] = 1'b1;
      ret_sched[r + 2] = 1'b1;
      ret_sched[r + 3] = 1'b1;
      ret_sched[r + 4] = 1'b1;
      exp_issue.push_back(r + 1);
      exp_issue.push_back(r + 6);
      exp_done.push_back(r + 15);
      repeat (20) @(negedge clk);
      auto_lat = 8;
      #4;
      chk("full_infl", {29'd0, inflight}, 32'd4);
      chk("full_ready", {31'd0, src_ready}, 32'd0);
      @(negedge clk);
      #4;
      chk("freed_infl", {29'd0, inflight}, 32'd3);
      chk("freed_ready", {31'd0, src_ready}, 32'd1);
      wait_done(100);

      // fire and retire in the same cycle with two in flight
      auto_lat = 10;
      start_pass(4, 4, s);
      t0 = s + 1;
      exp_done.push_back(t0 + 26);
      repeat (10) @(negedge clk);
      #4;
      chk("same_infl", {29'd0, inflight}, 32'd2);
      chk("same_fire", {31'd0, norm_enable & norm_out_valid}, 32'd1);
      @(negedge clk);
      #4;
      chk("same_after", {29'd0, inflight}, 32'd2);
      wait_done(100);

      // cfg=0 goes straight to DONE
      auto_lat = 0;
      start_pass(0, 0, s);
      exp_done.push_back(s + 1);
      for (int i = 0; i < 3; i++) begin
         #4;
         chk("zero_busy", {31'd0, busy}, 32'd0);
         @(negedge clk);
      end
      wait_done(20);

      // stray retire in IDLE sets a sticky err
      ret_sched[cyc + 1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #4;
      chk("err_set", {31'd0, err}, 32'd1);
      chk("err_infl", {29'd0, inflight}, 32'd0);
      err_chk_en = 1'b1;
      auto_lat = 8;
      start_pass(3, 3, s);
      exp_done.push_back(s + 20);
      wait_done(100);
      err_chk_en = 1'b0;
      #4;
      chk("err_hold", {31'd0, err}, 32'd1);

      // reset mid-pass with three in flight
      auto_lat = 0;
      start_pass(8, 3, s);
      t0 = s + 1;
      repeat (12) @(negedge clk);
      reset = 1'b1;
      #4;
      chk("pre_rst_infl", {29'd0, inflight}, 32'd3);
      @(negedge clk);
      reset = 1'b0;
      #4;
      chk_idle_outputs("midrst");
      exp_issue.delete();
      auto_lat = 8;
      start_pass(2, 2, s);
      exp_done.push_back(s + 15);
      wait_done(100);
      #4;
      chk("final_err", {31'd0, err}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
